// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry path: scanner FSM states, key functions
// and the key_code -> function/digit map.
package keypad_pkg;

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, HOLD, RELEASE} kstate_e;

  typedef enum logic [1:0] {KF_DIGIT, KF_BACKSPACE, KF_ENTER, KF_NONE} kfunc_e;

  typedef struct packed {
    kfunc_e     func;
    logic [3:0] digit;
  } kmap_t;

  // 4x4 uses the classic telephone-style layout; other geometries treat
  // codes 0..15 as hex digits, 16 as backspace, 17 as enter.
  function automatic kmap_t key_map(input int unsigned code,
                                    input int unsigned rows,
                                    input int unsigned cols);
    kmap_t m;
    m.func  = KF_NONE;
    m.digit = 4'd0;
    if (rows == 4 && cols == 4) begin
      case (code)
        0, 1, 2:  begin m.func = KF_DIGIT; m.digit = 4'(code + 1); end
        3:        begin m.func = KF_DIGIT; m.digit = 4'hA; end
        4, 5, 6:  begin m.func = KF_DIGIT; m.digit = 4'(code); end
        7:        begin m.func = KF_DIGIT; m.digit = 4'hB; end
        8, 9, 10: begin m.func = KF_DIGIT; m.digit = 4'(code - 1); end
        11:       begin m.func = KF_DIGIT; m.digit = 4'hC; end
        12:       m.func = KF_BACKSPACE;
        13:       begin m.func = KF_DIGIT; m.digit = 4'h0; end
        14:       m.func = KF_ENTER;
        15:       begin m.func = KF_DIGIT; m.digit = 4'hD; end
        default:  m.func = KF_NONE;
      endcase
    end else begin
      if (code < 16)       begin m.func = KF_DIGIT; m.digit = 4'(code); end
      else if (code == 16) m.func = KF_BACKSPACE;
      else if (code == 17) m.func = KF_ENTER;
    end
    return m;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with press debounce, hold and release debounce.
// Emits a combinational accept strobe plus registered key_valid/key_code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 200000,
  localparam int KW             = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  input  logic [ROWS-1:0] row_i,
  output logic [COLS-1:0] col_o,
  output kstate_e         state_o,
  output logic            accept_o,
  output logic [KW-1:0]   accept_code_o,
  output logic            key_valid_o,
  output logic [KW-1:0]   key_code_o
);

  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_DIV - 1);
  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);

  kstate_e         state_q, state_d;
  logic [CIW-1:0]  col_q, col_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [RIW-1:0]  ridx_q, ridx_d;
  logic            key_valid_q;
  logic [KW-1:0]   key_code_q;
  logic [RIW-1:0]  low_idx;
  logic            any_low;

  always_comb begin
    low_idx = '0;
    any_low = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_i[r]) begin
        low_idx = RIW'(r);
        any_low = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= '1;
      ridx_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      ridx_q      <= ridx_d;
      key_valid_q <= accept_o;
      if (accept_o) key_code_q <= accept_code_o;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    ridx_d  = ridx_q;
    case (state_q)
      IDLE: if (enable_i) begin
        state_d = SCAN;
        col_d   = '0;
        cnt_d   = '0;
      end
      SCAN: begin
        if (!enable_i) state_d = IDLE;
        else if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (any_low) begin
            state_d = DEBOUNCE;
            pat_d   = row_i;
            ridx_d  = low_idx;
          end else begin
            col_d = (col_q == CIW'(COLS - 1)) ? '0 : col_q + CIW'(1);
          end
        end else cnt_d = cnt_q + CNTW'(1);
      end
      DEBOUNCE: begin
        if (!enable_i) state_d = IDLE;
        else if (row_i != pat_q) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (accept_o) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNTW'(1);
      end
      HOLD: if (&row_i) begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (!(&row_i)) cnt_d = '0;
        else if (cnt_q == DEB_LAST) begin
          state_d = enable_i ? SCAN : IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNTW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_o         = (state_q == IDLE) ? '1 : ~(COLS'(1) << col_q);
    accept_o      = (state_q == DEBOUNCE) && enable_i && (row_i == pat_q) &&
                    (cnt_q == DEB_LAST);
    accept_code_o = KW'(int'(ridx_q) * COLS + int'(col_q));
    state_o       = state_q;
    key_valid_o   = key_valid_q;
    key_code_o    = key_code_q;
  end

endmodule

// File: rtl/keypad_entry_unit.sv
// Keypad entry top: scanner plus hex/decimal accumulator with backspace and
// enter, handing the entered value to the consumer on input_complete.
module keypad_entry_unit
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          input_enable,
  input  logic                          radix_dec,
  input  logic [ROWS-1:0]               row_in,
  output logic [COLS-1:0]               col_out,
  output logic [DATA_WIDTH-1:0]         display_value,
  output logic [DATA_WIDTH-1:0]         input_data,
  output logic                          input_complete,
  output logic                          key_valid,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code
);

  localparam int KW = $clog2(ROWS * COLS);
  localparam int DW = DATA_WIDTH;

  kstate_e       state;
  logic          accept;
  logic [KW-1:0] accept_code;
  kmap_t         km;
  logic [DW-1:0] acc_q, acc_d, data_q, data_d;
  logic          done_q, done_d;

  keypad_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scan (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (input_enable),
    .row_i         (row_in),
    .col_o         (col_out),
    .state_o       (state),
    .accept_o      (accept),
    .accept_code_o (accept_code),
    .key_valid_o   (key_valid),
    .key_code_o    (key_code)
  );

  assign km = key_map(int'(accept_code), ROWS, COLS);

  // Dropping input_enable aborts the entry, unless a key is still being released.
  always_comb begin
    acc_d  = acc_q;
    data_d = data_q;
    done_d = 1'b0;
    if (!input_enable && state != HOLD && state != RELEASE) acc_d = '0;
    else if (accept) begin
      case (km.func)
        KF_DIGIT: begin
          if (!radix_dec)          acc_d = {acc_q[DW-5:0], km.digit};
          else if (km.digit < 4'd10) acc_d = acc_q * DW'(10) + DW'(km.digit);
        end
        KF_BACKSPACE: acc_d = radix_dec ? '0 : (acc_q >> 4);
        KF_ENTER: begin
          data_d = acc_q;
          done_d = 1'b1;
          acc_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign display_value  = acc_q;
  assign input_data     = data_q;
  assign input_complete = done_q;

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Bench for keypad_entry_unit: keypad matrix model, key scoreboard checked on
// every key_valid pulse, plus directed scan/abort/reset checks.
module tb_keypad_entry_unit;

  localparam int ROWS = 4, COLS = 4, SD = 4, DB = 8, DW = 32;

  logic            clk = 1'b0;
  logic            rst, input_enable, radix_dec;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [DW-1:0]   display_value, input_data;
  logic            input_complete, key_valid;
  logic [3:0]      key_code;

  keypad_entry_unit #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .input_enable(input_enable), .radix_dec(radix_dec),
    .row_in(row_in), .col_out(col_out), .display_value(display_value),
    .input_data(input_data), .input_complete(input_complete),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed contact pulls its row low while its column is driven.
  logic contact;
  int   pcode;
  always_comb begin
    row_in = '1;
    if (contact && !col_out[pcode % COLS]) row_in[pcode / COLS] = 1'b0;
  end

  typedef struct {
    logic [3:0]  code;
    logic [31:0] disp;
    logic        enter;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] macc;
  int          checks = 0, errors = 0, kv_cnt = 0;
  logic        ic_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic push_key(input int code);
    exp_t       x;
    logic [3:0] d;
    bit         dig;
    x.code = 4'(code); x.enter = 1'b0; x.data = '0;
    d = 4'd0; dig = 1'b1;
    case (code)
      0: d = 4'd1;   1: d = 4'd2;   2: d = 4'd3;   3: d = 4'hA;
      4: d = 4'd4;   5: d = 4'd5;   6: d = 4'd6;   7: d = 4'hB;
      8: d = 4'd7;   9: d = 4'd8;  10: d = 4'd9;  11: d = 4'hC;
      13: d = 4'd0; 15: d = 4'hD;
      default: dig = 1'b0;
    endcase
    if (dig) begin
      if (!radix_dec)     macc = (macc << 4) | 32'(d);
      else if (d < 4'd10) macc = macc * 32'd10 + 32'(d);
    end else if (code == 12) macc = radix_dec ? 32'd0 : (macc >> 4);
    else if (code == 14) begin
      x.enter = 1'b1; x.data = macc; macc = '0;
    end
    x.disp = macc;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    ic_prev <= input_complete;
    if (ic_prev) chk("ic_one_cycle", input_complete, 1'b0);
    if (input_complete) chk("ic_with_key", key_valid, 1'b1);
    if (!rst && key_valid) begin
      kv_cnt <= kv_cnt + 1;
      if (sb.size() == 0) chk("kv_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("key_code", key_code, e.code);
        chk("display", display_value, e.disp);
        chk("input_complete", input_complete, e.enter);
        if (e.enter) chk("input_data", input_data, e.data);
      end
    end
  end

  task automatic press(input int code, input int hold);
    int start, n;
    push_key(code);
    start = kv_cnt;
    pcode = code; contact = 1'b1;
    n = 0;
    while (kv_cnt == start && n < 200) begin @(negedge clk); n++; end
    chk("press_seen", n < 200, 1'b1);
    repeat (hold) @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
    chk("one_key_per_press", kv_cnt - start, 1);
  endtask

  task automatic wait_col0();
    int n = 0;
    while (col_out == 4'b1110 && n < 100) begin @(negedge clk); n++; end
    while (col_out != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    chk("wait_col0", n < 100, 1'b1);
  endtask

  logic [3:0] colpat [4];
  int         base;

  initial begin
    colpat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1; input_enable = 1'b0; radix_dec = 1'b0;
    contact = 1'b0; pcode = 0; macc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_col", col_out, 4'hF);
    chk("rst_disp", display_value, 0);
    chk("rst_data", input_data, 0);
    chk("rst_ic", input_complete, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_code", key_code, 0);
    repeat (3) @(negedge clk);
    chk("idle_col", col_out, 4'hF);

    input_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("col_scan", col_out, colpat[(i / 4) % 4]);
    end

    // hex entry 1,2,C then enter
    radix_dec = 1'b0;
    press(0, 5); press(1, 5); press(11, 5);
    chk("hex_12C", display_value, 32'h12C);
    press(14, 5);
    chk("enter_data", input_data, 32'h12C);
    chk("enter_clr", display_value, 0);

    // decimal 4,2,A,backspace
    radix_dec = 1'b1;
    press(4, 5); press(1, 5);
    chk("dec_42", display_value, 32'd42);
    press(3, 5);
    chk("dec_A_ign", display_value, 32'd42);
    press(12, 5);
    chk("dec_bs", display_value, 0);

    // hex overflow 1..9
    radix_dec = 1'b0;
    foreach (colpat[i]) ;
    begin
      int codes [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      foreach (codes[i]) press(codes[i], 2);
    end
    chk("hex_ovf", display_value, 32'h23456789);
    press(14, 2);

    // decimal overflow 9999999999
    radix_dec = 1'b1;
    repeat (10) press(10, 2);
    chk("dec_ovf", display_value, 32'h540BE3FF);
    press(14, 2);
    chk("dec_ovf_data", input_data, 32'h540BE3FF);

    // long hold must not repeat
    radix_dec = 1'b0;
    press(13, 100);

    // bounce: short contact rejected, then one accepted press
    push_key(0);
    base = kv_cnt;
    wait_col0();
    pcode = 0; contact = 1'b1;
    repeat (5) @(negedge clk);
    contact = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_short", kv_cnt - base, 0);
    wait_col0();
    repeat (3) @(negedge clk);
    contact = 1'b1;
    repeat (10) @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
    chk("bounce_one", kv_cnt - base, 1);
    chk("bounce_disp", display_value, 32'h1);

    // abort while scanning
    press(8, 3);
    input_enable = 1'b0;
    @(negedge clk);
    chk("abort_disp", display_value, 0);
    chk("abort_col", col_out, 4'hF);
    macc = '0;

    // reset during debounce
    input_enable = 1'b1;
    press(5, 3);
    base = kv_cnt;
    wait_col0();
    pcode = 0; contact = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; input_enable = 1'b0;
    @(negedge clk);
    chk("rstdb_kv", key_valid, 0);
    chk("rstdb_disp", display_value, 0);
    chk("rstdb_data", input_data, 0);
    chk("rstdb_col", col_out, 4'hF);
    chk("rstdb_code", key_code, 0);
    chk("rstdb_ic", input_complete, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    contact = 1'b0;
    chk("rstdb_nokey", kv_cnt - base, 0);
    macc = '0;

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
